// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared state encodings, owner ids and error read value
package bus_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_AUX = 1'b1;
  localparam logic [63:0] ERR_RDATA = '0;
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: two-way round-robin owner picker with a forced master-1 grant
module rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       force_m1,
  output logic       owner
);
  // a lock re-grant beats round-robin; a tie goes to whoever did not own last
  always_comb owner = (force_m1 && req[1]) ? OWN_AUX : (&req) ? ~last_owner : req[1] ? OWN_AUX : OWN_CPU;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin bus arbiter with master-1 lock and slave-ack timeout
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_wen,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_done,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_wen,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_done,
  output logic          err,
  output logic          s_req,
  output logic [AW-1:0] s_addr,
  output logic          s_wen,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ack,
  output logic          stall_o
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam int LW = $clog2(LOCK_MAX + 1);
  state_t        state_q;
  logic          owner_q, last_owner_q, force_q, wen_q, err_q, owner_d, busy, done;
  logic [CW-1:0] cnt_q;
  logic [LW-1:0] lock_cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  rr_pick u_pick (
    .req       ({m1_req, m0_req}),
    .last_owner(last_owner_q),
    .force_m1  (force_q),
    .owner     (owner_d)
  );
  // transaction FSM: arbitrate in IDLE, hold the slave request in BUSY, report in DONE
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_AUX;
      force_q      <= 1'b0;
      cnt_q        <= '0;
      lock_cnt_q   <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          force_q <= 1'b0;
          if (!(force_q && m1_req)) lock_cnt_q <= '0;
          if (m0_req || m1_req) begin
            owner_q <= owner_d;
            addr_q  <= owner_d ? m1_addr : m0_addr;
            wen_q   <= owner_d ? m1_wen : m0_wen;
            wdata_q <= owner_d ? m1_wdata : m0_wdata;
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (s_ack) begin
            rdata_q <= s_rdata;
            err_q   <= 1'b0;
            state_q <= S_DONE;
          end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            rdata_q <= DW'(ERR_RDATA);
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          last_owner_q <= owner_q;
          cnt_q        <= '0;
          state_q      <= S_IDLE;
          if (owner_q == OWN_AUX && m1_lock && lock_cnt_q < LW'(LOCK_MAX - 1)) begin
            force_q    <= 1'b1;
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end else begin
            force_q    <= 1'b0;
            lock_cnt_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  // outputs decode straight from registered state; slave fields are zero outside BUSY
  always_comb begin
    busy     = state_q == S_BUSY;
    done     = state_q == S_DONE;
    s_req    = busy;
    s_addr   = busy ? addr_q : '0;
    s_wen    = busy && wen_q;
    s_wdata  = (busy && wen_q) ? wdata_q : '0;
    m0_done  = done && owner_q == OWN_CPU;
    m1_done  = done && owner_q == OWN_AUX;
    m0_rdata = m0_done ? rdata_q : '0;
    m1_rdata = m1_done ? rdata_q : '0;
    err      = done && err_q;
    stall_o  = m0_req && !m0_done;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of arbitration, lock, timeout, write hold and reset abort
module tb_bus_arbiter;
  logic        cpu_clk = 1'b0, cpu_rst = 1'b1;
  logic        m0_req = 0, m0_wen = 0, m1_req = 0, m1_lock = 0, m1_wen = 0, s_ack = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, s_rdata = 0;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        m0_done, m1_done, err, s_req, s_wen, stall_o;
  int          total = 0, npass = 0;

  bus_arbiter dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_done(m0_done),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wen(m1_wen),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_done(m1_done),
    .err(err), .s_req(s_req), .s_addr(s_addr), .s_wen(s_wen), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .stall_o(stall_o)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic step();
    @(posedge cpu_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    step(); step();
    chk("rst_s_req", s_req, 0); chk("rst_m0_done", m0_done, 0); chk("rst_m1_done", m1_done, 0);
    chk("rst_err", err, 0); chk("rst_s_wen", s_wen, 0); chk("rst_stall", stall_o, 0);
    cpu_rst = 0;
    s_ack = 1; s_rdata = 32'h1234_5678;
    step();
    chk("idle_ack_ignored", {s_req, m0_done, m1_done}, 0);
    // 1: single m0 read with same-cycle ack
    m0_req = 1; m0_addr = 32'h0000_1000;
    #1 chk("t1_stall_c0", stall_o, 1);
    step();
    chk("t1_busy_s_req", s_req, 1); chk("t1_busy_addr", s_addr, 32'h1000);
    chk("t1_busy_wen", s_wen, 0); chk("t1_stall_c1", stall_o, 1); chk("t1_no_done_c1", m0_done, 0);
    step();
    chk("t1_done", m0_done, 1); chk("t1_rdata", m0_rdata, 32'h1234_5678);
    chk("t1_err", err, 0); chk("t1_stall_done", stall_o, 0); chk("t1_s_req_done", s_req, 0);
    m0_req = 0; s_ack = 0;
    step();
    chk("t1_done_pulse", m0_done, 0);
    // 2: tie after reset -> m0, then alternation
    cpu_rst = 1; step(); cpu_rst = 0;
    m0_req = 1; m1_req = 1; m0_addr = 32'h100; m1_addr = 32'h200; s_ack = 1; s_rdata = 32'h0BAD_F00D;
    step(); chk("t2_first_m0", s_addr, 32'h100);
    step(); chk("t2_m0_done", {m0_done, m1_done}, 2'b10);
    step(); chk("t2_idle", s_req, 0);
    step(); chk("t2_then_m1", s_addr, 32'h200);
    step(); chk("t2_m1_done", {m0_done, m1_done}, 2'b01); chk("t2_m1_rdata", m1_rdata, 32'h0BAD_F00D);
    step();
    step(); chk("t2_alt_m0", s_addr, 32'h100);
    step(); chk("t2_alt_m0_done", m0_done, 1);
    m0_req = 0; m1_req = 0;
    step();
    // 3: m1 lock with m0 pending, LOCK_MAX=4
    m0_req = 1; m1_req = 1; m1_lock = 1;
    for (int k = 0; k < 4; k++) begin
      step(); chk($sformatf("t3_m1_busy%0d", k), s_addr, 32'h200); chk($sformatf("t3_stall%0d", k), stall_o, 1);
      step(); chk($sformatf("t3_m1_done%0d", k), {m0_done, m1_done}, 2'b01);
      step();
    end
    step(); chk("t3_m0_granted", s_addr, 32'h100);
    step(); chk("t3_m0_done", {m0_done, m1_done}, 2'b10);
    m0_req = 0; m1_req = 0; m1_lock = 0;
    step();
    // 4: timeout on a read, then a normal transaction
    m0_req = 1; m0_addr = 32'h300; s_ack = 0; s_rdata = 32'hFFFF_FFFF;
    step();
    for (int i = 1; i < 16; i++) begin
      step(); chk($sformatf("t4_wait%0d", i), {s_req, m0_done}, 2'b10);
    end
    step();
    chk("t4_to_done", m0_done, 1); chk("t4_to_err", err, 1); chk("t4_to_rdata", m0_rdata, 0);
    m0_req = 0;
    step(); chk("t4_err_pulse", err, 0);
    m1_req = 1; s_ack = 1; s_rdata = 32'h5555_AAAA;
    step(); step();
    chk("t4_next_done", m1_done, 1); chk("t4_next_err", err, 0); chk("t4_next_rdata", m1_rdata, 32'h5555_AAAA);
    m1_req = 0; s_ack = 0;
    step();
    // 5: m0 write held through a 5-cycle ack delay
    chk("t5_idle_wen", s_wen, 0);
    m0_req = 1; m0_wen = 1; m0_addr = 32'h8000_0000; m0_wdata = 32'hA5A5_A5A5;
    step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t5_hold%0d", i), {s_req, s_wen, s_addr, s_wdata}, {2'b11, 32'h8000_0000, 32'hA5A5_A5A5});
      if (i == 5) s_ack = 1;
      step();
    end
    chk("t5_done", m0_done, 1); chk("t5_err", err, 0); chk("t5_done_wen", {s_wen, s_wdata}, 0);
    m0_req = 0; m0_wen = 0; s_ack = 0;
    step();
    // 6: reset during an m1 BUSY, then a fresh m0 read
    m1_req = 1; m1_addr = 32'h400;
    step(); chk("t6_busy", s_req, 1);
    step();
    cpu_rst = 1;
    step(); chk("t6_rst_s_req", s_req, 0); chk("t6_rst_no_done", m1_done, 0);
    cpu_rst = 0; m1_req = 0;
    step(); chk("t6_idle", {s_req, m1_done}, 0);
    m0_req = 1; m0_addr = 32'h500; s_ack = 1; s_rdata = 32'h0000_0077;
    step(); chk("t6_m0_addr", s_addr, 32'h500);
    step(); chk("t6_m0_done", m0_done, 1); chk("t6_m0_rdata", m0_rdata, 32'h77);
    m0_req = 0; s_ack = 0;
    step();
    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end
endmodule
